// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt controller feeding the single Interrupt input of the
// mips core. External request lines are edge-detected, and a free-running
// periodic timer adds one more source. Every event is latched as a pending
// bit. The pending bits are masked and prioritised, and one request at a
// time is presented to the core.
//
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   irq_in     - external request levels (rising edge = event)
//   mask_we    - write strobe for the mask register
//   mask_wdata - new mask value, bit = 1 enables the source
//   int_ack    - one-cycle pulse, core entered the handler
//   int_done   - one-cycle pulse, core returned from the handler
//   Interrupt  - registered request to the core
//   int_cause  - index of the source being requested or serviced
//   in_service - high while the handler runs
//   pending    - pending bits (bit NSRC is the timer)
//   mask       - current mask register
module intr_ctrl #(
    parameter int            NSRC         = 4,
    parameter int            TIMER_PERIOD = 15,
    parameter int            TIMER_EN     = 1,
    parameter logic [NSRC:0] MASK_RST     = '1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_in,
    input  logic            mask_we,
    input  logic [NSRC:0]   mask_wdata,
    input  logic            int_ack,
    input  logic            int_done,
    output logic            Interrupt,
    output logic [2:0]      int_cause,
    output logic            in_service,
    output logic [NSRC:0]   pending,
    output logic [NSRC:0]   mask
);

    localparam int            TW        = $clog2(TIMER_PERIOD);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMER_PERIOD - 1);
    localparam logic [TW-1:0] TCNT_ONE  = TW'(1);
    localparam logic [NSRC:0] ONE_HOT0  = {{NSRC{1'b0}}, 1'b1};
    localparam logic          TIMER_ON  = 1'(TIMER_EN != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [NSRC-1:0] irq_prev_r;
    logic [TW-1:0]   tcnt_r;
    logic [TW-1:0]   tcnt_s;
    logic [NSRC:0]   pending_r;
    logic [NSRC:0]   pending_s;
    logic [NSRC:0]   mask_r;
    logic [2:0]      cause_r;
    logic [2:0]      cause_s;
    logic            interrupt_r;
    logic            in_service_r;
    logic [NSRC-1:0] edge_s;
    logic            wrap_s;
    logic [NSRC:0]   set_s;
    logic [NSRC:0]   clr_s;
    logic [NSRC:0]   eligible_s;

    // Lowest set index wins; the timer sits at the top index so it loses to
    // every external line.
    function automatic logic [2:0] prio_pick(input logic [NSRC:0] v);
        logic [2:0] pick;
        pick = 3'd0;
        for (int i = NSRC; i >= 0; i--) begin
            if (v[i]) begin
                pick = 3'(i);
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Event sources: rising edges on irq_in and the timer wrap.
    always_comb begin
        edge_s     = irq_in & ~irq_prev_r;
        wrap_s     = (tcnt_r == TCNT_LAST);
        set_s      = {wrap_s & TIMER_ON, edge_s};
        eligible_s = pending_r & mask_r;
        if (wrap_s) begin
            tcnt_s = '0;
        end else begin
            tcnt_s = tcnt_r + TCNT_ONE;
        end
    end

    // Request FSM next state, cause capture and pending clear on ack.
    always_comb begin
        state_s = state_r;
        cause_s = cause_r;
        clr_s   = '0;
        case (state_r)
            ST_IDLE: begin
                if (|eligible_s) begin
                    state_s = ST_REQ;
                    cause_s = prio_pick(eligible_s);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Cause stays frozen here; only the ack moves us on.
                if (int_ack) begin
                    state_s = ST_SERVICE;
                    clr_s   = ONE_HOT0 << cause_r;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (int_done) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SERVICE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Set after clear: an event landing on the ack edge is kept.
        pending_s = (pending_r & ~clr_s) | set_s;
    end

    // State, status and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            irq_prev_r   <= '0;
            tcnt_r       <= '0;
            pending_r    <= '0;
            mask_r       <= MASK_RST;
            cause_r      <= 3'd0;
            interrupt_r  <= 1'b0;
            in_service_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            irq_prev_r   <= irq_in;
            tcnt_r       <= tcnt_s;
            pending_r    <= pending_s;
            cause_r      <= cause_s;
            interrupt_r  <= (state_s == ST_REQ);
            in_service_r <= (state_s == ST_SERVICE);
            if (mask_we) begin
                mask_r <= mask_wdata;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    assign Interrupt  = interrupt_r;
    assign int_cause  = cause_r;
    assign in_service = in_service_r;
    assign pending    = pending_r;
    assign mask       = mask_r;

endmodule

// File: tb/tb_intr_ctrl.sv
// Testbench for intr_ctrl: directed vectors with a request scoreboard.
module tb_intr_ctrl;

    localparam int NSRC = 4;

    logic            clk;
    logic            rst;
    logic [NSRC-1:0] irq_in;
    logic            mask_we;
    logic [NSRC:0]   mask_wdata;
    logic            int_ack;
    logic            int_done;
    logic            Interrupt;
    logic [2:0]      int_cause;
    logic            in_service;
    logic [NSRC:0]   pending;
    logic [NSRC:0]   mask;

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_q[$];
    logic       int_seen;
    logic [2:0] exp_cause;

    intr_ctrl #(
        .NSRC(NSRC),
        .TIMER_PERIOD(15),
        .TIMER_EN(1),
        .MASK_RST(5'b11111)
    ) dut (
        .clk(clk),
        .rst(rst),
        .irq_in(irq_in),
        .mask_we(mask_we),
        .mask_wdata(mask_wdata),
        .int_ack(int_ack),
        .int_done(int_done),
        .Interrupt(Interrupt),
        .int_cause(int_cause),
        .in_service(in_service),
        .pending(pending),
        .mask(mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_mask(input logic [NSRC:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        tick();
        mask_we    = 1'b0;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic pulse_done();
        int_done = 1'b1;
        tick();
        int_done = 1'b0;
    endtask

    // Monitor: every new request must match the next expected cause.
    initial begin
        int_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (Interrupt === 1'b1 && int_seen == 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_request actual_cause=%0d expected=none", int_cause);
                end else begin
                    exp_cause = exp_q.pop_front();
                    check("req_cause", 32'(int_cause), 32'(exp_cause));
                end
            end
            int_seen = Interrupt;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        irq_in     = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        int_ack    = 1'b0;
        int_done   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_interrupt", 32'(Interrupt), 32'd0);
        check("rst_in_service", 32'(in_service), 32'd0);
        check("rst_cause", 32'(int_cause), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_mask", 32'(mask), 32'h1f);

        // Timer only: pending[4] after edge 15, request after edge 16
        exp_q.push_back(3'd4);
        repeat (14) tick();
        check("t1_pend_e14", 32'(pending), 32'd0);
        tick();
        check("t1_pend_e15", 32'(pending), 32'h10);
        check("t1_int_e15", 32'(Interrupt), 32'd0);
        tick();
        check("t1_int_e16", 32'(Interrupt), 32'd1);
        check("t1_cause_e16", 32'(int_cause), 32'd4);
        repeat (3) tick();
        check("t1_int_hold", 32'(Interrupt), 32'd1);
        pulse_ack();
        check("t1_int_after_ack", 32'(Interrupt), 32'd0);
        check("t1_insvc", 32'(in_service), 32'd1);
        check("t1_pend_clr", 32'(pending), 32'd0);
        check("t1_cause_svc", 32'(int_cause), 32'd4);
        pulse_done();
        check("t1_insvc_done", 32'(in_service), 32'd0);

        // Priority and freeze (timer masked)
        do_reset();
        set_mask(5'b01111);
        check("t2_mask", 32'(mask), 32'h0f);
        tick();
        irq_in = 4'b1000;
        exp_q.push_back(3'd3);
        tick();
        check("t2_pend_e3", 32'(pending[3:0]), 32'h8);
        check("t2_int_e3", 32'(Interrupt), 32'd0);
        tick();
        check("t2_int_e4", 32'(Interrupt), 32'd1);
        check("t2_cause_e4", 32'(int_cause), 32'd3);
        irq_in = 4'b1001;
        tick();
        check("t2_pend_e5", 32'(pending[3:0]), 32'h9);
        check("t2_cause_frozen", 32'(int_cause), 32'd3);
        pulse_ack();
        check("t2_insvc", 32'(in_service), 32'd1);
        check("t2_pend_ack", 32'(pending[3:0]), 32'h1);
        check("t2_cause_svc", 32'(int_cause), 32'd3);
        exp_q.push_back(3'd0);
        pulse_done();
        check("t2_gap_int", 32'(Interrupt), 32'd0);
        tick();
        check("t2_back2back_int", 32'(Interrupt), 32'd1);
        check("t2_back2back_cause", 32'(int_cause), 32'd0);
        pulse_ack();
        pulse_done();
        irq_in = '0;

        // Masking
        do_reset();
        set_mask(5'b01110);
        irq_in = 4'b0001;
        tick();
        check("t3_pend_masked", 32'(pending[3:0]), 32'h1);
        tick();
        tick();
        check("t3_int_masked", 32'(Interrupt), 32'd0);
        exp_q.push_back(3'd0);
        set_mask(5'b01111);
        check("t3_mask_new", 32'(mask), 32'h0f);
        check("t3_int_e_write", 32'(Interrupt), 32'd0);
        tick();
        check("t3_int_unmasked", 32'(Interrupt), 32'd1);
        check("t3_cause", 32'(int_cause), 32'd0);
        pulse_ack();
        pulse_done();
        irq_in = '0;

        // Level held high: one event only
        do_reset();
        set_mask(5'b01111);
        irq_in = 4'b0100;
        exp_q.push_back(3'd2);
        tick();
        check("t4_pend", 32'(pending[3:0]), 32'h4);
        tick();
        check("t4_cause", 32'(int_cause), 32'd2);
        pulse_ack();
        pulse_done();
        repeat (15) tick();
        check("t4_int_after", 32'(Interrupt), 32'd0);
        check("t4_pend_after", 32'(pending[3:0]), 32'h0);
        irq_in = '0;

        // Collision: new edge on the ack edge survives
        do_reset();
        set_mask(5'b01111);
        irq_in = 4'b0010;
        exp_q.push_back(3'd1);
        tick();
        tick();
        check("t5_int", 32'(Interrupt), 32'd1);
        irq_in = 4'b0000;
        tick();
        irq_in = 4'b0010;
        exp_q.push_back(3'd1);
        pulse_ack();
        check("t5_pend_setwins", 32'(pending[3:0]), 32'h2);
        check("t5_insvc", 32'(in_service), 32'd1);
        pulse_done();
        tick();
        check("t5_second_int", 32'(Interrupt), 32'd1);
        check("t5_second_cause", 32'(int_cause), 32'd1);
        pulse_ack();
        pulse_done();
        irq_in = '0;

        // Reset while in SERVICE
        do_reset();
        irq_in = 4'b0001;
        exp_q.push_back(3'd0);
        tick();
        tick();
        pulse_ack();
        check("t6_insvc_before", 32'(in_service), 32'd1);
        irq_in = '0;
        do_reset();
        check("t6_int", 32'(Interrupt), 32'd0);
        check("t6_insvc", 32'(in_service), 32'd0);
        check("t6_cause", 32'(int_cause), 32'd0);
        check("t6_pend", 32'(pending), 32'd0);
        check("t6_mask", 32'(mask), 32'h1f);
        pulse_done();
        check("t6_insvc_done", 32'(in_service), 32'd0);
        check("t6_int_done", 32'(Interrupt), 32'd0);
        check("t6_pend_done", 32'(pending), 32'd0);

        tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt controller that sits directly upstream of the `mips` core and drives its single `Interrupt` input. It merges NSRC external request lines and one built-in periodic timer source. It latches every request as a pending bit, masks and prioritises the pending bits, and presents one request at a time to the core. The core acknowledges when it enters the handler and signals completion when it returns.

## Interface
- NSRC, 4: number of external interrupt lines, 1..7; source index NSRC is the timer.
- TIMER_PERIOD, 15: timer period in clock cycles, minimum 2.
- TIMER_EN, 1: 1 enables the timer source; 0 ties the timer pending bit to 0.
- MASK_RST, all ones (NSRC+1 bits): reset value of the enable mask.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  NSRC  external request levels; the rising edge is the event.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  NSRC+1  new mask; bit = 1 means the source is enabled.
- int_ack  in  1  one-cycle pulse: core has taken the interrupt (handler entry).
- int_done  in  1  one-cycle pulse: core has finished the handler (return from exception).
- Interrupt  out  1  request to the core.
- int_cause  out  3  index of the source being requested or serviced.
- in_service  out  1  high while the handler runs.
- pending  out  NSRC+1  pending bits, readable as a status word.
- mask  out  NSRC+1  current mask register.

## Operation
- Edge detection:
  - `irq_prev` holds the previous sample of `irq_in`.
  - `irq_in[i]` = 1 with `irq_prev[i]` = 0 sets `pending[i]`.
  - A level held high produces exactly one event.
- Timer:
  - `tcnt` counts 0..TIMER_PERIOD-1 and wraps to 0.
  - On the wrap edge, `pending[NSRC]` is set.
  - The timer free-runs and is not affected by the mask or by the FSM.
- Masking:
  - Masked sources still latch their pending bit.
  - Only `pending & mask` is eligible to request.
  - Unmasking a source with its pending bit already set makes it eligible on the next cycle.
- Priority: lowest index wins; the timer is lowest priority.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: when `pending & mask` ≠ 0, load `int_cause` with the winner and go to REQ. `int_ack` and `int_done` are ignored.
  - REQ: hold `Interrupt` = 1 and keep `int_cause` frozen; later higher-priority arrivals and mask changes do not alter it. On `int_ack`, go to SERVICE and clear `pending[int_cause]`. `int_done` is ignored.
  - SERVICE: `Interrupt` = 0 and `in_service` = 1. No nesting: new events only latch. On `int_done`, go to IDLE. `int_ack` is ignored.
- Simultaneous set and clear of the same pending bit (new edge or timer wrap on the ack edge): set wins, so the event is not lost.
- A `mask_we` write takes effect on the next edge. It affects eligibility in IDLE only.
- Asserting `rst` mid-operation, in any state, returns the block to reset state on that edge. Any outstanding request is dropped.

## Timing
- Reset values:
  - `Interrupt`, `in_service`, `int_cause`, `pending`, `tcnt`, `irq_prev` = 0.
  - `mask` = MASK_RST.
  - State = IDLE.
- External latency:
  - `irq_in` first sampled high at edge k → `pending[i]` visible after edge k.
  - `Interrupt` high after edge k+1, when the block is IDLE and the source is unmasked.
- Timer latency: the first `pending[NSRC]` is set at the TIMER_PERIOD-th edge after reset deasserts, then every TIMER_PERIOD edges.
- `Interrupt` is registered and stays high until the edge that samples `int_ack`; it is low the following cycle.
- Back-to-back service: from IDLE with a remaining eligible source, `Interrupt` is reasserted one cycle after the edge that samples `int_done`, so there is a minimum of one idle cycle between requests.
- `int_cause` is stable from REQ entry through SERVICE exit.

## Test plan
- Timer only (defaults, `irq_in` = 0, no ack): `pending[4]` set after edge 15; `Interrupt` = 1, `int_cause` = 4 after edge 16; holds until ack.
- Priority and freeze: `irq_in` = 4'b1000 at edge 3, then 4'b1001 at edge 5 → `int_cause` = 3 stays frozen. Ack → SERVICE, `pending` = 5'b00001. Done → next request `int_cause` = 0.
- Masking: `mask` = 5'b11110 and an edge on `irq_in[0]` → `pending[0]` = 1 but `Interrupt` stays 0. Write `mask` = 5'b11111 → `Interrupt` after 1 cycle with `int_cause` = 0.
- Level held: `irq_in[2]` held high 20 cycles with one ack/done pair → exactly one service; `pending[2]` = 0 afterwards.
- Collision: new rising edge on `irq_in[1]` sampled on the same edge as `int_ack` for cause 1 → after done, a second request with `int_cause` = 1 appears.
- Reset in SERVICE: `rst` = 1 for one edge while `in_service` = 1 → all outputs at reset values. Subsequent `int_done` ignored; `mask` = 5'b11111.
